// File: rtl/diff_clk_ibuf.sv
// diff_clk_ibuf: differential clock receiver with pair-fault and per-window edge-count monitor
module diff_clk_ibuf #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int FAULT_CYCLES  = 4,
  parameter int MIN_EDGES     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I,
  input  logic        IB,
  output logic        O,
  output logic        pair_fault,
  output logic        clk_ok,
  output logic [15:0] edge_count,
  output logic        count_valid
);
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam int FW = $clog2(FAULT_CYCLES + 1);
  logic [1:0] i_sync, ib_sync;
  logic si, sib, so, so_d, rise, last, win_fault;
  logic [FW-1:0] fcnt;
  logic [WW-1:0] wcnt;
  logic [15:0] acc, acc_nxt;
  assign O = I & ~IB & rst_n;
  assign si = i_sync[1];
  assign sib = ib_sync[1];
  assign so = si & ~sib;
  assign rise = so & ~so_d;
  assign pair_fault = fcnt == FW'(FAULT_CYCLES);
  assign last = wcnt == WW'(WINDOW_CYCLES - 1);
  assign acc_nxt = (rise && acc != 16'hFFFF) ? acc + 16'd1 : acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_sync <= '0;
      ib_sync <= '0;
      so_d <= 1'b0;
      fcnt <= '0;
      wcnt <= '0;
      acc <= '0;
      win_fault <= 1'b0;
      edge_count <= '0;
      clk_ok <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      i_sync <= {i_sync[0], I};
      ib_sync <= {ib_sync[0], IB};
      so_d <= so;
      fcnt <= (si != sib) ? '0 : pair_fault ? fcnt : fcnt + FW'(1);
      wcnt <= last ? '0 : wcnt + WW'(1);
      acc <= last ? '0 : acc_nxt;
      win_fault <= last ? 1'b0 : win_fault | pair_fault;
      edge_count <= last ? acc_nxt : edge_count;
      clk_ok <= last ? (acc_nxt >= 16'(MIN_EDGES)) && !(win_fault || pair_fault) : clk_ok;
      count_valid <= last;
    end
  end
endmodule

// File: tb/tb_diff_clk_ibuf.sv
// tb_diff_clk_ibuf: randomized directed bench checking diff_clk_ibuf against a sample-history model
module tb_diff_clk_ibuf;
  localparam int W = 1024, F = 4, M = 8;
  logic clk = 1'b0, rst_n = 1'b0, I = 1'b0, IB = 1'b1;
  logic O, pair_fault, clk_ok, count_valid;
  logic [15:0] edge_count;
  int vectors = 0, miscompares = 0;
  bit s_i[$], s_ib[$];
  int k, m_acc, m_last_cnt;
  bit m_wf, m_last_ok;
  always #5 clk = ~clk;
  diff_clk_ibuf #(.WINDOW_CYCLES(W), .FAULT_CYCLES(F), .MIN_EDGES(M)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .IB(IB), .O(O), .pair_fault(pair_fault),
    .clk_ok(clk_ok), .edge_count(edge_count), .count_valid(count_valid)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, k);
    end
  endtask
  // s_i[j] is the leg value captured at edge j; the synchronized leg in cycle j is s_i[j-1]
  function automatic bit so_at(input int j);
    return j >= 1 && s_i[j-1] && !s_ib[j-1];
  endfunction
  function automatic bit eq_at(input int j);
    return j < 1 || s_i[j-1] == s_ib[j-1];
  endfunction
  function automatic bit pf_at(input int j);
    if (j < F) return 1'b0;
    for (int n = j - F; n < j; n++) if (!eq_at(n)) return 1'b0;
    return 1'b1;
  endfunction
  task automatic model_reset();
    s_i = {};
    s_ib = {};
    s_i.push_back(1'b0);
    s_ib.push_back(1'b0);
    k = 0;
    m_acc = 0;
    m_wf = 1'b0;
    m_last_cnt = 0;
    m_last_ok = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_O"}, O, 16'd0);
    chk({tag, "_pair_fault"}, pair_fault, 16'd0);
    chk({tag, "_clk_ok"}, clk_ok, 16'd0);
    chk({tag, "_edge_count"}, edge_count, 16'd0);
    chk({tag, "_count_valid"}, count_valid, 16'd0);
  endtask
  // entered and left on a falling clk edge
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    I = 1'b1;
    IB = 1'b0;
    #1 chk_idle("rst_async");
    repeat (n) begin
      @(negedge clk);
      I = ~I;
      IB = ~I;
      #1 chk_idle("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic step(input bit ni, input bit nib);
    bit pf;
    I = ni;
    IB = nib;
    #1 chk("O", O, 16'(ni & ~nib));
    @(posedge clk);
    s_i.push_back(ni);
    s_ib.push_back(nib);
    k++;
    #1;
    if (k % W == 0) begin
      m_last_cnt = m_acc;
      m_last_ok = m_acc >= M && !m_wf;
      m_acc = 0;
      m_wf = 1'b0;
    end
    chk("count_valid", count_valid, 16'(k % W == 0));
    chk("edge_count", edge_count, 16'(m_last_cnt));
    chk("clk_ok", clk_ok, 16'(m_last_ok));
    pf = pf_at(k);
    chk("pair_fault", pair_fault, 16'(pf));
    if (so_at(k) && !so_at(k - 1) && m_acc < 65535) m_acc++;
    m_wf |= pf;
    @(negedge clk);
  endtask
  initial begin
    bit v, b;
    int o, r;
    @(negedge clk);
    do_reset(8);
    for (int n = 0; n < 2 * W; n++) begin
      v = ((k >> 2) & 1) != 0;
      step(v, !v);
    end
    for (int n = 0; n < W + W / 2; n++) step(1'b1, 1'b1);
    for (int n = 0; n < 2 * W + 16; n++) begin
      v = ((k >> 2) & 1) != 0;
      b = (n == 40) || ($urandom_range(0, 31) == 0);
      step(v, b ? v : !v);
    end
    r = 0;
    for (int n = 0; n < 3 * W; n++) begin
      o = (k + 1) % W;
      if (o == 1) r = $urandom_range(0, 50);
      v = o >= W - 2 || o == 0 || (o >= 100 + r && o < 103 + r) || (o >= 300 + r && o < 303 + r)
          || (o >= 500 + r && o < 503 + r) || (o >= 700 + r && o < 703 + r);
      step(v, !v);
    end
    for (int n = 0; n < 2 * W; n++) begin
      v = $urandom_range(0, 1) != 0;
      b = $urandom_range(0, 3) == 0;
      step(v, b ? v : !v);
    end
    while (k % W != 500) begin
      v = ((k >> 2) & 1) != 0;
      step(v, !v);
    end
    do_reset(3);
    for (int n = 0; n < W + 16; n++) begin
      v = ((k >> 2) & 1) != 0;
      step(v, !v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
